// File: rtl/cva6_instr_sequencer_if.sv
// cva6_instr_sequencer_if: program-load, start, issue-handshake, memory-response and status signals of the sequencer.
// The slave modport is the sequencer side and the master modport is the driving side.
interface cva6_instr_sequencer_if #(
   parameter int NUM_INSTR = 4,
   parameter int CNT_W     = 16
);
   localparam int AW = $clog2(NUM_INSTR);
   logic              prog_we_i;
   logic [AW-1:0]     prog_addr_i;
   logic [31:0]       prog_data_i;
   logic              start_i;
   logic [31:0]       instr_o;
   logic              instr_valid_o;
   logic              instr_ready_i;
   logic              load_mem_resp_i;
   logic              store_mem_resp_i;
   logic              busy_o;
   logic              done_o;
   logic [AW:0]       pc_o;
   logic [CNT_W-1:0]  cycles_o;
   modport slave (
      input  prog_we_i, prog_addr_i, prog_data_i, start_i, instr_ready_i,
             load_mem_resp_i, store_mem_resp_i,
      output instr_o, instr_valid_o, busy_o, done_o, pc_o, cycles_o
   );
   modport master (
      output prog_we_i, prog_addr_i, prog_data_i, start_i, instr_ready_i,
             load_mem_resp_i, store_mem_resp_i,
      input  instr_o, instr_valid_o, busy_o, done_o, pc_o, cycles_o
   );
endinterface

// File: rtl/cva6_instr_sequencer.sv
// cva6_instr_sequencer: issues a small stored program to a core shim, one slot per valid/ready transfer.
// Macro SEQ_MEM_RESP_WAIT_EN: MEMWAIT waits for the matching memory response instead of a single bubble.
module cva6_instr_sequencer #(
   parameter int NUM_INSTR = 4,
   parameter int CNT_W     = 16
) (
   input logic                   clk_i,
   input logic                   rst_i,
   cva6_instr_sequencer_if.slave bus
);
   localparam int AW = $clog2(NUM_INSTR);
   localparam logic [AW:0] PC_END = (AW+1)'(NUM_INSTR);
   localparam logic [AW:0] PC_LAST = (AW+1)'(NUM_INSTR - 1);
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   typedef enum logic [1:0] {IDLE, ISSUE, MEMWAIT, DONE} state_t;
   state_t r_state, w_next;
   logic [AW:0] r_pc;
   logic [CNT_W-1:0] r_cycles;
   logic [31:0] r_slot [NUM_INSTR];
   logic [31:0] w_instr;
   logic w_idle, w_fire, w_mem, w_mem_exit;
   assign w_idle = (r_state == IDLE) || (r_state == DONE);
   assign w_fire = (r_state == ISSUE) && bus.instr_ready_i;
   assign w_instr = (r_pc < PC_END) ? r_slot[r_pc[AW-1:0]] : '0;
   assign w_mem = (w_instr[6:0] == OP_LOAD) || (w_instr[6:0] == OP_STORE);
`ifdef SEQ_MEM_RESP_WAIT_EN
   logic r_is_load;
   assign w_mem_exit = r_is_load ? bus.load_mem_resp_i : bus.store_mem_resp_i;
   always_ff @(posedge clk_i) begin
      if (rst_i) r_is_load <= 1'b0;
      else if (w_fire) r_is_load <= (w_instr[6:0] == OP_LOAD);
   end
`else
   logic w_unused;
   assign w_unused = bus.load_mem_resp_i ^ bus.store_mem_resp_i;
   assign w_mem_exit = 1'b1;
`endif
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: w_next = bus.start_i ? ISSUE : r_state;
         ISSUE:      w_next = !w_fire ? ISSUE : w_mem ? MEMWAIT : (r_pc == PC_LAST) ? DONE : ISSUE;
         MEMWAIT:    w_next = !w_mem_exit ? MEMWAIT : (r_pc < PC_END) ? ISSUE : DONE;
         default:    w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_pc     <= '0;
         r_cycles <= '0;
         for (int i = 0; i < NUM_INSTR; i++) r_slot[i] <= '0;
      end else begin
         r_state <= w_next;
         if (w_idle && bus.prog_we_i) r_slot[bus.prog_addr_i] <= bus.prog_data_i;
         if (w_idle && bus.start_i) begin
            r_pc     <= '0;
            r_cycles <= '0;
         end else begin
            if (w_fire) r_pc <= r_pc + 1'b1;
            if (!w_idle && r_cycles != '1) r_cycles <= r_cycles + 1'b1;
         end
      end
   end
   assign bus.instr_o       = w_instr;
   assign bus.instr_valid_o = (r_state == ISSUE);
   assign bus.busy_o        = (r_state == ISSUE) || (r_state == MEMWAIT);
   assign bus.done_o        = (r_state == DONE);
   assign bus.pc_o          = r_pc;
   assign bus.cycles_o      = r_cycles;
endmodule

// File: tb/tb_cva6_instr_sequencer.sv
// tb_cva6_instr_sequencer: directed scenarios plus random traffic against a behavioural program-issue model.
module tb_cva6_instr_sequencer;
   localparam int N = 4;
   localparam int CW = 4;
   localparam int AW = 2;
   localparam int CMAX = (1 << CW) - 1;
   localparam logic [31:0] LW   = 32'h00002083;
   localparam logic [31:0] SW   = 32'h00102023;
   localparam logic [31:0] ADDI = 32'h00100093;
   localparam logic [31:0] ALU  = 32'h00000093;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_tot = 0;
   int n_pass = 0;
   cva6_instr_sequencer_if #(.NUM_INSTR(N), .CNT_W(CW)) bus ();
   cva6_instr_sequencer #(.NUM_INSTR(N), .CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   // behavioural model: program image, next slot, running/finished flags, pending memory wait
   logic [31:0] m_prog [N];
   logic [AW:0] m_pc;
   int m_cyc;
   bit m_busy, m_done, m_wait, m_wload, m_on;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask
   always @(posedge clk) begin
      logic [6:0] op;
      bit ex;
      if (rst) begin
         for (int i = 0; i < N; i++) m_prog[i] = '0;
         m_pc = '0; m_cyc = 0; m_busy = 0; m_done = 0; m_wait = 0; m_wload = 0; m_on = 1;
      end else if (!m_busy) begin
         if (bus.prog_we_i) m_prog[bus.prog_addr_i] = bus.prog_data_i;
         if (bus.start_i) begin
            m_pc = '0; m_cyc = 0; m_busy = 1; m_done = 0; m_wait = 0;
         end
      end else begin
         if (m_cyc < CMAX) m_cyc++;
         if (m_wait) begin
`ifdef SEQ_MEM_RESP_WAIT_EN
            ex = m_wload ? bus.load_mem_resp_i : bus.store_mem_resp_i;
`else
            ex = 1;
`endif
            if (ex) begin
               m_wait = 0;
               if (m_pc >= N) begin m_busy = 0; m_done = 1; end
            end
         end else if (bus.instr_ready_i) begin
            op = m_prog[m_pc[AW-1:0]][6:0];
            m_pc = m_pc + 1'b1;
            if (op == 7'b0000011 || op == 7'b0100011) begin
               m_wait = 1; m_wload = (op == 7'b0000011);
            end else if (m_pc == N) begin
               m_busy = 0; m_done = 1;
            end
         end
      end
   end
   always @(negedge clk) begin
      if (m_on) begin
         chk("valid", bus.instr_valid_o, m_busy && !m_wait);
         chk("instr", bus.instr_o, (m_pc < N) ? m_prog[m_pc[AW-1:0]] : 32'h0);
         chk("busy", bus.busy_o, m_busy);
         chk("done", bus.done_o, m_done);
         chk("pc", bus.pc_o, m_pc);
         chk("cycles", bus.cycles_o, m_cyc);
      end
   end
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   task automatic prog(input int a, input logic [31:0] d);
      bus.prog_we_i = 1; bus.prog_addr_i = a[AW-1:0]; bus.prog_data_i = d;
      tick();
      bus.prog_we_i = 0;
   endtask
   task automatic go();
      bus.start_i = 1;
      tick();
      bus.start_i = 0;
   endtask
   task automatic run_done(input string nm);
      int k = 0;
      bus.instr_ready_i = 1; bus.load_mem_resp_i = 1; bus.store_mem_resp_i = 1;
      while (!bus.done_o && k < 200) begin tick(); k++; end
      chk(nm, bus.done_o, 1);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [6:0] pat;
      logic [31:0] r;
      logic [6:0] op;
      bus.prog_we_i = 0; bus.prog_addr_i = '0; bus.prog_data_i = '0; bus.start_i = 0;
      bus.instr_ready_i = 0; bus.load_mem_resp_i = 0; bus.store_mem_resp_i = 0;
      tick(); tick();
      rst = 0;
      chk("rst_valid", bus.instr_valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_pc", bus.pc_o, 0);
      chk("rst_cycles", bus.cycles_o, 0);
      for (int i = 0; i < N; i++) prog(i, ALU);
      bus.instr_ready_i = 1;
      go();
      for (int i = 0; i < N; i++) begin
         chk("s1_valid", bus.instr_valid_o, 1);
         chk("s1_pc", bus.pc_o, i);
         tick();
      end
      chk("s1_done", bus.done_o, 1);
      chk("s1_pc_end", bus.pc_o, 4);
      chk("s1_cycles", bus.cycles_o, 4);
      prog(0, LW); prog(1, SW); prog(2, LW); prog(3, ADDI);
`ifndef SEQ_MEM_RESP_WAIT_EN
      bus.instr_ready_i = 1;
      go();
      pat = '0;
      for (int i = 0; i < 7; i++) begin
         pat = {pat[5:0], bus.instr_valid_o};
         tick();
      end
      chk("s2_pattern", pat, 7'b1010101);
      chk("s2_done", bus.done_o, 1);
      chk("s2_cycles", bus.cycles_o, 7);
`else
      bus.instr_ready_i = 1; bus.load_mem_resp_i = 0; bus.store_mem_resp_i = 0;
      go();
      chk("s3_issue_lw", bus.instr_valid_o, 1);
      tick();
      bus.store_mem_resp_i = 1;
      chk("s3_wait1", bus.instr_valid_o, 0);
      chk("s3_wait_pc", bus.pc_o, 1);
      tick();
      bus.store_mem_resp_i = 0;
      chk("s3_wait2", bus.instr_valid_o, 0);
      tick();
      bus.load_mem_resp_i = 1;
      chk("s3_wait3", bus.instr_valid_o, 0);
      tick();
      bus.load_mem_resp_i = 0;
      chk("s3_issue_sw", bus.instr_valid_o, 1);
      chk("s3_instr_sw", bus.instr_o, SW);
      run_done("s3_done");
`endif
      bus.instr_ready_i = 0;
      go();
      for (int i = 0; i < 5; i++) begin
         chk("s4_valid", bus.instr_valid_o, 1);
         chk("s4_instr", bus.instr_o, LW);
         chk("s4_pc", bus.pc_o, 0);
         tick();
      end
      bus.instr_ready_i = 1;
      tick();
      chk("s4_xfer_pc", bus.pc_o, 1);
      run_done("s4_done");
      go();
      tick(); tick(); tick();
      chk("s5_memwait", bus.busy_o && !bus.instr_valid_o, 1);
      chk("s5_pc2", bus.pc_o, 2);
      rst = 1;
      tick();
      rst = 0;
      chk("s5_rst_valid", bus.instr_valid_o, 0);
      chk("s5_rst_busy", bus.busy_o, 0);
      chk("s5_rst_pc", bus.pc_o, 0);
      bus.instr_ready_i = 0;
      go();
      chk("s5_slot0", bus.instr_o, 0);
      chk("s5_slot0_valid", bus.instr_valid_o, 1);
      run_done("s5_done");
      prog(0, 32'h00100093); prog(1, 32'h00200113); prog(2, 32'h00300193); prog(3, 32'h00400213);
      bus.instr_ready_i = 1;
      go();
      tick();
      bus.instr_ready_i = 0; bus.start_i = 1;
      bus.prog_we_i = 1; bus.prog_addr_i = '0; bus.prog_data_i = 32'hDEADBEEF;
      tick();
      bus.start_i = 0; bus.prog_we_i = 0;
      chk("s6_no_restart", bus.pc_o, 1);
      chk("s6_busy", bus.busy_o, 1);
      run_done("s6_done");
      bus.instr_ready_i = 0;
      go();
      chk("s6_restart_pc", bus.pc_o, 0);
      chk("s6_slot0", bus.instr_o, 32'h00100093);
      repeat (20) tick();
      chk("s7_saturate", bus.cycles_o, CMAX);
      run_done("s7_done");
      for (int i = 0; i < 3000; i++) begin
         r = $urandom();
         case ($urandom_range(0, 3))
            0: op = 7'b0000011;
            1: op = 7'b0100011;
            2: op = 7'b0010011;
            default: op = r[6:0];
         endcase
         bus.instr_ready_i    = $urandom_range(0, 3) != 0;
         bus.load_mem_resp_i  = $urandom_range(0, 2) == 0;
         bus.store_mem_resp_i = $urandom_range(0, 2) == 0;
         bus.prog_we_i        = $urandom_range(0, 3) == 0;
         bus.prog_addr_i      = AW'($urandom_range(0, N - 1));
         bus.prog_data_i      = {r[31:7], op};
         bus.start_i          = $urandom_range(0, 7) == 0;
         rst                  = $urandom_range(0, 299) == 0;
         tick();
      end
      rst = 0; bus.start_i = 0; bus.prog_we_i = 0;
      tick();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
